// File: rtl/datademux2out.sv
// Escape-steered 1-to-2 byte demux with a small FIFO and registered output per channel.
// Define DATADEMUX_STICKY_ERROR_EN to make `error` sticky until reset; otherwise it pulses per faulting cycle.
module datademux2out #(
    parameter logic [7:0] ESC   = 8'h10,
    parameter logic [7:0] SEL0  = 8'h30,
    parameter logic [7:0] SEL1  = 8'h31,
    parameter int         DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] d,
    input  logic       dv,
    input  logic       rdy0,
    input  logic       rdy1,
    output logic [7:0] od0,
    output logic       od0v,
    output logic [7:0] od1,
    output logic       od1v,
    output logic       sel,
    output logic       error
);

    localparam int        AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_ESCAPED = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       sel_nxt;
    logic       push;
    logic [7:0] push_data;
    logic       framing;
    logic [1:0] rdy_vec;
    logic [1:0] push_vec;
    logic [1:0] ovf;
    logic       fault;

    assign rdy_vec  = {rdy1, rdy0};
    assign push_vec = {push & sel, push & ~sel};
    assign fault    = framing | (|ovf);

    // Escape decoder: only cycles with dv advance the state machine.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        push      = 1'b0;
        push_data = d;
        framing   = 1'b0;
        if (dv) begin
            case (state)
                ST_NORMAL: begin
                    if (d == ESC) begin
                        state_nxt = ST_ESCAPED;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_NORMAL;
                    if (d == SEL0) begin
                        sel_nxt = 1'b0;
                    end else if (d == SEL1) begin
                        sel_nxt = 1'b1;
                    end else if (d == ESC) begin
                        push      = 1'b1;
                        push_data = ESC;
                    end else begin
                        framing = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_NORMAL;
            sel   <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
`ifdef DATADEMUX_STICKY_ERROR_EN
            error <= error | fault;
`else
            error <= fault;
`endif
        end
    end

    // Per-channel FIFO; fullness is judged on the pre-pop count so a same-cycle pop never makes room.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [AW:0]   count;
        logic [7:0]    od_q;
        logic          odv_q;
        logic          full;
        logic          do_push;
        logic          do_pop;

        assign full    = (count == CNT_FULL);
        assign do_push = push_vec[ch] & ~full;
        assign do_pop  = (count != '0) & rdy_vec[ch];
        assign ovf[ch] = push_vec[ch] & full;

        always_ff @(posedge clk) begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                od_q   <= 8'h00;
                odv_q  <= 1'b0;
            end else begin
                odv_q <= do_pop;
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    od_q   <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign od0  = g_ch[0].od_q;
    assign od0v = g_ch[0].odv_q;
    assign od1  = g_ch[1].od_q;
    assign od1v = g_ch[1].odv_q;

endmodule

// File: tb/tb_datademux2out.sv
// Randomized scoreboard bench for datademux2out with a queue-based reference model.
module tb_datademux2out;

    localparam logic [7:0] ESC   = 8'h10;
    localparam logic [7:0] SEL0  = 8'h30;
    localparam logic [7:0] SEL1  = 8'h31;
    localparam int         DEPTH = 4;

    logic       clk;
    logic       resetn;
    logic [7:0] d;
    logic       dv;
    logic       rdy0;
    logic       rdy1;
    logic [7:0] od0;
    logic       od0v;
    logic [7:0] od1;
    logic       od1v;
    logic       sel;
    logic       error;

    datademux2out #(
        .ESC(ESC), .SEL0(SEL0), .SEL1(SEL1), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .d(d), .dv(dv), .rdy0(rdy0), .rdy1(rdy1),
        .od0(od0), .od0v(od0v), .od1(od1), .od1v(od1v), .sel(sel), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic s;
        logic e;
        logic v0;
        logic v1;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [7:0] mf[2][$];
    logic [7:0] sb[2][$];
    bit         m_esc;
    bit         m_sel;
    bit         m_err;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_clear();
        m_esc = 1'b0;
        m_sel = 1'b0;
        m_err = 1'b0;
        for (int c = 0; c < 2; c++) begin
            mf[c].delete();
            sb[c].delete();
        end
        exp_q.delete();
    endfunction

    // One clock of stimulus; the model predicts what the DUT shows after the edge.
    task automatic cycle(input logic [7:0] db, input logic dvb, input logic r0, input logic r1);
        exp_t       e;
        bit         fault;
        bit         do_push;
        bit         full;
        int         ch;
        logic [1:0] rv;
        d    = db;
        dv   = dvb;
        rdy0 = r0;
        rdy1 = r1;
        rv      = {r1, r0};
        fault   = 1'b0;
        do_push = 1'b0;
        ch      = int'(m_sel);
        if (dvb) begin
            if (!m_esc) begin
                if (db == ESC) m_esc = 1'b1;
                else do_push = 1'b1;
            end else begin
                m_esc = 1'b0;
                if (db == SEL0) m_sel = 1'b0;
                else if (db == SEL1) m_sel = 1'b1;
                else if (db == ESC) do_push = 1'b1;
                else fault = 1'b1;
            end
        end
        e.v0 = (mf[0].size() > 0) && rv[0];
        e.v1 = (mf[1].size() > 0) && rv[1];
        full = (mf[ch].size() >= DEPTH);
        if (e.v0) void'(mf[0].pop_front());
        if (e.v1) void'(mf[1].pop_front());
        if (do_push) begin
            if (full) begin
                fault = 1'b1;
            end else begin
                mf[ch].push_back(db);
                sb[ch].push_back(db);
            end
        end
`ifdef DATADEMUX_STICKY_ERROR_EN
        m_err = m_err | fault;
`else
        m_err = fault;
`endif
        e.s = m_sel;
        e.e = m_err;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic r0, input logic r1);
        for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, r0, r1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_od0"}, {24'd0, od0}, 32'h0);
        chk({tag, "_od0v"}, {31'd0, od0v}, 32'h0);
        chk({tag, "_od1"}, {24'd0, od1}, 32'h0);
        chk({tag, "_od1v"}, {31'd0, od1v}, 32'h0);
        chk({tag, "_sel"}, {31'd0, sel}, 32'h0);
        chk({tag, "_error"}, {31'd0, error}, 32'h0);
    endtask

    // Asynchronous reset asserted mid-cycle, released away from the clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        model_clear();
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Monitor: compares per-cycle control/valid expectations and pops data from the scoreboards.
    always @(negedge clk) begin
        if (resetn) begin
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sel", {31'd0, sel}, {31'd0, e.s});
                chk("error", {31'd0, error}, {31'd0, e.e});
                chk("od0v", {31'd0, od0v}, {31'd0, e.v0});
                chk("od1v", {31'd0, od1v}, {31'd0, e.v1});
            end
            if (od0v === 1'b1) begin
                if (sb[0].size() == 0) chk("od0_unexpected", {24'd0, od0}, 32'hFFFF_FFFF);
                else chk("od0_data", {24'd0, od0}, {24'd0, sb[0].pop_front()});
            end
            if (od1v === 1'b1) begin
                if (sb[1].size() == 0) chk("od1_unexpected", {24'd0, od1}, 32'hFFFF_FFFF);
                else chk("od1_data", {24'd0, od1}, {24'd0, sb[1].pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] rb;
        resetn = 1'b0;
        d      = 8'h00;
        dv     = 1'b0;
        rdy0   = 1'b0;
        rdy1   = 1'b0;
        model_clear();
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        resetn = 1'b1;

        // Routing
        cycle(8'hA5, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Channel switch
        cycle(8'h10, 1'b1, 1'b1, 1'b1);
        cycle(8'h31, 1'b1, 1'b1, 1'b1);
        cycle(8'h42, 1'b1, 1'b1, 1'b1);
        cycle(8'h10, 1'b1, 1'b1, 1'b1);
        cycle(8'h30, 1'b1, 1'b1, 1'b1);
        cycle(8'h43, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Literal escape, then framing fault; escape state held across a gap
        cycle(8'h10, 1'b1, 1'b1, 1'b1);
        cycle(8'h10, 1'b1, 1'b1, 1'b1);
        cycle(8'h10, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b1);
        cycle(8'h7F, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Overflow on channel 0
        for (int i = 1; i <= 5; i++) cycle(8'(i), 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b1);
        idle(6, 1'b1, 1'b1);

        // Independence: channel 1 stalled with two bytes, channel 0 streams
        cycle(8'h10, 1'b1, 1'b1, 1'b0);
        cycle(8'h31, 1'b1, 1'b1, 1'b0);
        cycle(8'hB1, 1'b1, 1'b1, 1'b0);
        cycle(8'hB2, 1'b1, 1'b1, 1'b0);
        cycle(8'h10, 1'b1, 1'b1, 1'b0);
        cycle(8'h30, 1'b1, 1'b1, 1'b0);
        cycle(8'hC1, 1'b1, 1'b1, 1'b0);
        cycle(8'hC2, 1'b1, 1'b1, 1'b0);
        cycle(8'hC3, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b1);

        // Reset mid-stream: both FIFOs loaded, escape pending
        cycle(8'h10, 1'b1, 1'b0, 1'b0);
        cycle(8'h31, 1'b1, 1'b0, 1'b0);
        cycle(8'hD1, 1'b1, 1'b0, 1'b0);
        cycle(8'h10, 1'b1, 1'b0, 1'b0);
        cycle(8'h30, 1'b1, 1'b0, 1'b0);
        cycle(8'hD0, 1'b1, 1'b0, 1'b0);
        cycle(8'h10, 1'b1, 1'b0, 1'b0);
        cycle(8'h22, 1'b1, 1'b0, 1'b0);
        cycle(8'h10, 1'b1, 1'b0, 1'b0);
        do_reset("midrst");
        cycle(8'h31, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rb = ESC;
                3:       rb = SEL0;
                4:       rb = SEL1;
                default: rb = 8'($urandom);
            endcase
            cycle(rb, 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(2 * DEPTH + 4, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("drain_ch0", sb[0].size(), 32'd0);
        chk("drain_ch1", sb[1].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datademux2out.md
# datademux2out

Splits one byte stream into two byte streams, steered by in-band escape sequences; the receive-side counterpart of the two-input data mux, used where a merged link must be fanned back out to two consumers. Each output channel has its own FIFO and a per-channel ready input, so one stalled consumer never blocks the other. Framing and overflow faults are reported on `error`.

## Interface
- `ESC`, 8'h10, escape byte value.
- `SEL0`, 8'h30, byte following `ESC` that selects channel 0.
- `SEL1`, 8'h31, byte following `ESC` that selects channel 1.
- `DEPTH`, 4, entries per channel FIFO (power of two, ≥2).
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `d`  in  8  input byte.
- `dv`  in  1  `d` valid this cycle (no backpressure; one byte per cycle).
- `rdy0`  in  1  channel 0 consumer can accept a byte.
- `rdy1`  in  1  channel 1 consumer can accept a byte.
- `od0`  out  8  channel 0 byte, registered.
- `od0v`  out  1  `od0` valid, one cycle per byte.
- `od1`  out  8  channel 1 byte, registered.
- `od1v`  out  1  `od1` valid, one cycle per byte.
- `sel`  out  1  current destination channel, registered.
- `error`  out  1  fault indication (see Configuration).

## Operation
- Reset values:
  - `od0`, `od1` = 8'h00.
  - `od0v`, `od1v`, `sel`, `error` = 0.
  - FSM = NORMAL.
  - Both FIFOs empty.
- FSM, advances only on cycles with `dv`=1:
  - NORMAL, `d`≠`ESC`: push `d` to FIFO[`sel`].
  - NORMAL, `d`=`ESC`: go to ESCAPED; nothing pushed.
  - ESCAPED, `d`=`SEL0`: `sel`←0; go to NORMAL.
  - ESCAPED, `d`=`SEL1`: `sel`←1; go to NORMAL.
  - ESCAPED, `d`=`ESC`: push literal `ESC` to FIFO[`sel`]; go to NORMAL.
  - ESCAPED, any other byte: byte dropped; framing fault; go to NORMAL; `sel` unchanged.
- ESCAPED persists indefinitely across `dv`=0 gaps.
- Overflow fault: a push to a full FIFO drops the byte. Full is evaluated before that cycle's pop, so a same-cycle pop does not make room.
- Drain, per channel, independent: when FIFO[n] is non-empty and `rdyn`=1, pop, load `odn`, and assert `odnv` for one cycle. `odnv`=0 otherwise; `odn` holds its last value.
- Both channels may push and pop in the same cycle. One FIFO may push and pop in the same cycle (when not full).
- Fault = framing fault OR overflow fault. Reading an empty FIFO cannot occur by construction.

## Timing
- Latency: `dv` in cycle 0 (FIFO empty, `rdy`=1) → `odnv`=1 in cycle 2.
- `sel` changes the cycle after the select byte is sampled. A data byte immediately following a select sequence goes to the new channel.
- Sustained throughput: one byte/cycle per channel while `rdy` is held.
- `error` asserts the cycle after the faulting input byte is sampled.
- `resetn` low at any time: immediate asynchronous clear to the reset values. All FIFO contents and any pending escape state are lost.

## Configuration
- `DATADEMUX_STICKY_ERROR_EN` defined: `error` is sticky, set by any fault and cleared only by reset.
- Undefined: `error` is a one-cycle pulse per faulting cycle (framing and overflow ORed).

## Test plan
- Routing:
  - Stimulus: after reset, `d`=8'hA5 with `dv`, `rdy0`=1.
  - Response: `od0`=8'hA5 with `od0v`=1 two cycles later; `od1v` stays 0.
- Channel switch:
  - Stimulus: stream 8'h10, 8'h31, 8'h42, 8'h10, 8'h30, 8'h43.
  - Response: `od1`=8'h42 only, `od0`=8'h43 only; `sel` reads 1 then 0.
- Literal escape and framing fault:
  - Stimulus: 8'h10, 8'h10 on channel 0, then 8'h10, 8'h7F.
  - Response: `od0`=8'h10 once; 8'h7F never output; `error` asserted; `sel` stays 0.
- Overflow:
  - Stimulus: `rdy0`=0; push 5 bytes 8'h01..8'h05 with `DEPTH`=4.
  - Response: `error` after the 5th byte; on raising `rdy0`, exactly 8'h01..8'h04 are output on consecutive cycles.
- Independence:
  - Stimulus: `rdy1`=0 with channel 1 holding 2 bytes; stream 3 bytes to channel 0 with `rdy0`=1.
  - Response: all 3 bytes appear on `od0` with no stall; channel 1 bytes are released only when `rdy1` rises.
- Reset mid-stream:
  - Stimulus: drop `resetn` while in ESCAPED with both FIFOs non-empty.
  - Response: all outputs 0 at once; after release, 8'h31 is routed as data to channel 0; sticky `error` cleared (macro defined).
